// File: rtl/crisp_pkg.sv
// Shared opcode constants and operand-select encoding for the ID->EX operand stage.
package crisp_pkg;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef enum logic [2:0] {
    SEL_RS,
    SEL_IMM,
    SEL_PC,
    SEL_ZERO,
    SEL_FOUR
  } op_sel_e;

  typedef struct packed {
    op_sel_e a;
    op_sel_e b;
  } op_sel_t;

  // Unknown opcodes fall through as register/register so the ALU sees raw sources.
  function automatic op_sel_t decode_sel(input logic [6:0] opcode);
    op_sel_t sel;
    sel.a = SEL_RS;
    sel.b = SEL_RS;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR: sel.b = SEL_IMM;
      OPC_LUI: begin
        sel.a = SEL_ZERO;
        sel.b = SEL_IMM;
      end
      OPC_AUIPC: begin
        sel.a = SEL_PC;
        sel.b = SEL_IMM;
      end
      OPC_JAL: begin
        sel.a = SEL_PC;
        sel.b = SEL_FOUR;
      end
      default: ;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-source bypass: picks EX/MEM, then MEM/WB, then the held register value; x0 is never bypassed.
module fwd_mux #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter bit FWD_EN  = 1'b1
) (
  input  logic [RADDR_W-1:0] addr,
  input  logic [XLEN-1:0]    held,
  input  logic               exm_wb_en,
  input  logic [RADDR_W-1:0] exm_rd,
  input  logic [XLEN-1:0]    exm_data,
  input  logic               mwb_wb_en,
  input  logic [RADDR_W-1:0] mwb_rd,
  input  logic [XLEN-1:0]    mwb_data,
  output logic [XLEN-1:0]    fwd
);

  generate
    if (FWD_EN) begin : g_fwd
      always_comb begin
        fwd = held;
        if (addr != '0) begin
          if (exm_wb_en && (exm_rd == addr)) begin
            fwd = exm_data;
          end else if (mwb_wb_en && (mwb_rd == addr)) begin
            fwd = mwb_data;
          end
        end
      end
    end else begin : g_raw
      logic unused_fwd;
      assign unused_fwd = ^{addr, exm_wb_en, exm_rd, exm_data, mwb_wb_en, mwb_rd, mwb_data};
      assign fwd = held;
    end
  endgenerate

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: holds one decoded instruction, bypasses late results into its
// sources every cycle it is held, and presents opcode-selected ALU operands.
module id_ex_stage
  import crisp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter bit FWD_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [RADDR_W-1:0] id_rs1_addr,
  input  logic [RADDR_W-1:0] id_rs2_addr,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [6:0]         id_opcode,
  input  logic [2:0]         id_funct3,
  input  logic [6:0]         id_funct7,
  input  logic               exm_wb_en,
  input  logic [RADDR_W-1:0] exm_rd,
  input  logic [XLEN-1:0]    exm_data,
  input  logic               mwb_wb_en,
  input  logic [RADDR_W-1:0] mwb_rd,
  input  logic [XLEN-1:0]    mwb_data,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [XLEN-1:0]    ex_a,
  output logic [XLEN-1:0]    ex_b,
  output logic [6:0]         ex_opcode,
  output logic [2:0]         ex_funct3,
  output logic [6:0]         ex_funct7,
  output logic [RADDR_W-1:0] ex_rd,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_store
);

  localparam logic [XLEN-1:0] CONST_FOUR = XLEN'(4);

  logic               valid_reg;
  logic [XLEN-1:0]    pc_reg;
  logic [RADDR_W-1:0] rs1_addr_reg;
  logic [RADDR_W-1:0] rs2_addr_reg;
  logic [RADDR_W-1:0] rd_reg;
  logic [XLEN-1:0]    imm_reg;
  logic [6:0]         opcode_reg;
  logic [2:0]         funct3_reg;
  logic [6:0]         funct7_reg;
  logic [XLEN-1:0]    rs1_val_reg;
  logic [XLEN-1:0]    rs2_val_reg;

  logic               capture;
  logic [RADDR_W-1:0] src_addr [2];
  logic [XLEN-1:0]    src_held [2];
  logic [XLEN-1:0]    src_fwd  [2];
  op_sel_t            sel;
  logic [XLEN-1:0]    a_next;
  logic [XLEN-1:0]    b_next;

  assign id_ready = !valid_reg || ex_ready;
  assign capture  = id_valid && id_ready;

  assign src_addr[0] = rs1_addr_reg;
  assign src_addr[1] = rs2_addr_reg;
  assign src_held[0] = rs1_val_reg;
  assign src_held[1] = rs2_val_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      fwd_mux #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W),
        .FWD_EN  (FWD_EN)
      ) u_fwd (
        .addr      (src_addr[gi]),
        .held      (src_held[gi]),
        .exm_wb_en (exm_wb_en),
        .exm_rd    (exm_rd),
        .exm_data  (exm_data),
        .mwb_wb_en (mwb_wb_en),
        .mwb_rd    (mwb_rd),
        .mwb_data  (mwb_data),
        .fwd       (src_fwd[gi])
      );
    end
  endgenerate

  // While stalled the source values absorb whatever is retiring, so a one-cycle writeback is not missed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg    <= 1'b0;
      pc_reg       <= '0;
      rs1_addr_reg <= '0;
      rs2_addr_reg <= '0;
      rd_reg       <= '0;
      imm_reg      <= '0;
      opcode_reg   <= '0;
      funct3_reg   <= '0;
      funct7_reg   <= '0;
      rs1_val_reg  <= '0;
      rs2_val_reg  <= '0;
    end else begin
      if (flush) begin
        valid_reg <= 1'b0;
      end else if (capture) begin
        valid_reg <= 1'b1;
      end else if (ex_ready) begin
        valid_reg <= 1'b0;
      end

      if (capture && !flush) begin
        pc_reg       <= id_pc;
        rs1_addr_reg <= id_rs1_addr;
        rs2_addr_reg <= id_rs2_addr;
        rd_reg       <= id_rd_addr;
        imm_reg      <= id_imm;
        opcode_reg   <= id_opcode;
        funct3_reg   <= id_funct3;
        funct7_reg   <= id_funct7;
        rs1_val_reg  <= id_rs1_data;
        rs2_val_reg  <= id_rs2_data;
      end else if (valid_reg && !ex_ready) begin
        rs1_val_reg <= src_fwd[0];
        rs2_val_reg <= src_fwd[1];
      end
    end
  end

  always_comb begin
    sel    = decode_sel(opcode_reg);
    a_next = '0;
    b_next = '0;
    case (sel.a)
      SEL_RS:   a_next = src_fwd[0];
      SEL_IMM:  a_next = imm_reg;
      SEL_PC:   a_next = pc_reg;
      SEL_FOUR: a_next = CONST_FOUR;
      default:  a_next = '0;
    endcase
    case (sel.b)
      SEL_RS:   b_next = src_fwd[1];
      SEL_IMM:  b_next = imm_reg;
      SEL_PC:   b_next = pc_reg;
      SEL_FOUR: b_next = CONST_FOUR;
      default:  b_next = '0;
    endcase
  end

  // Nothing leaks downstream while the stage is empty.
  assign ex_valid  = valid_reg;
  assign ex_a      = valid_reg ? a_next      : '0;
  assign ex_b      = valid_reg ? b_next      : '0;
  assign ex_store  = valid_reg ? src_fwd[1]  : '0;
  assign ex_opcode = valid_reg ? opcode_reg  : '0;
  assign ex_funct3 = valid_reg ? funct3_reg  : '0;
  assign ex_funct7 = valid_reg ? funct7_reg  : '0;
  assign ex_rd     = valid_reg ? rd_reg      : '0;
  assign ex_pc     = valid_reg ? pc_reg      : '0;

endmodule
